// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : counter_pkg
// Description : Shared widths, reset value and default prescaler ratio for
//               the demo counter blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam logic [3:0]  CNT_RST = 4'hF;
    localparam int unsigned DIV_W   = 32;

    // 50 MHz / 50_000_000 gives a 1 Hz step.
    localparam logic [DIV_W-1:0] CLK_DIV_DEFAULT = 32'd50_000_000;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/clk_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_tick_gen
// Description : Prescaler producing a one-cycle enable tick every CLK_DIV
//               clocks. Reusable by any blink/counter block.
//   clk_50M : system clock, rising-edge active
//   Reset   : synchronous active-high reset, clears the prescaler
//   tick    : high for the single cycle in which the prescaler is at
//             CLK_DIV-1 (combinational from the prescaler register)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_tick_gen
    import counter_pkg::*;
#(
    parameter logic [DIV_W-1:0] CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk_50M,
    input  logic Reset,
    output logic tick
);

    localparam logic [DIV_W-1:0] c_last = CLK_DIV - 32'd1;

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    // With CLK_DIV=1 the terminal value is 0, so the tick stays high
    // continuously and the counter never leaves 0.
    assign w_tick = (r_div_cnt == c_last);

    always_ff @(posedge clk_50M) begin
        if (Reset) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 32'd1;
        end
    end

    assign tick = w_tick;

endmodule : clk_tick_gen
`default_nettype wire

// File: rtl/block_counter4bit_down.sv
`default_nettype none
// ============================================================================
// Module      : block_counter4bit_down
// Description : Free-running 4-bit down-counter stepped once per prescaler
//               tick, wrapping 0 -> 15.
//   clk_50M : system clock, rising-edge active
//   Reset   : synchronous active-high reset, loads 15 and restarts prescaler
//   Output  : registered count value
// Revision    : 1.0 - initial release
// ============================================================================
module block_counter4bit_down
    import counter_pkg::*;
#(
    parameter logic [DIV_W-1:0] CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic             clk_50M,
    input  logic             Reset,
    output logic [CNT_W-1:0] Output
);

    logic             w_tick;
    logic [CNT_W-1:0] r_count;

    clk_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_50M (clk_50M),
        .Reset   (Reset),
        .tick    (w_tick)
    );

    // Reset wins over a coincident tick; natural 4-bit underflow gives the
    // 0 -> 15 wrap.
    always_ff @(posedge clk_50M) begin
        if (Reset) begin
            r_count <= CNT_RST;
        end else if (w_tick) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign Output = r_count;

endmodule : block_counter4bit_down
`default_nettype wire

// File: tb/tb_block_counter4bit_down.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_counter4bit_down
// Description : Self-checking bench for block_counter4bit_down. Two
//               instances (CLK_DIV=4 and CLK_DIV=1) are compared every cycle
//               against a reference that derives the count from the number
//               of edges since the last reset edge; directed checks cover
//               step timing, wrap, mid-count reset and reset priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_counter4bit_down;

    logic       clk;
    logic       rst4;
    logic       rst1;
    logic [3:0] out4;
    logic [3:0] out1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: edges elapsed since last reset edge, and validity.
    int n4 = 0;
    int n1 = 0;
    bit v4 = 1'b0;
    bit v1 = 1'b0;

    block_counter4bit_down #(.CLK_DIV(32'd4)) u_dut4 (
        .clk_50M (clk),
        .Reset   (rst4),
        .Output  (out4)
    );

    block_counter4bit_down #(.CLK_DIV(32'd1)) u_dut1 (
        .clk_50M (clk),
        .Reset   (rst1),
        .Output  (out1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_value(input string tag, input logic [3:0] obs,
                               input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Count value = 15 minus completed periods, modulo 16.
    function automatic logic [3:0] model_val(input int n, input int div);
        int steps;
        steps = (n / div) % 16;
        return 4'((15 - steps + 16) % 16);
    endfunction

    always @(posedge clk) begin
        if (rst4 === 1'b1) begin
            n4 = 0;
            v4 = 1'b1;
        end else if (v4) begin
            n4++;
        end
        if (rst1 === 1'b1) begin
            n1 = 0;
            v1 = 1'b1;
        end else if (v1) begin
            n1++;
        end
    end

    always @(negedge clk) begin
        if (v4) check_value("model_div4", out4, model_val(n4, 4));
        if (v1) check_value("model_div1", out1, model_val(n1, 1));
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] step_tbl [8];

    initial begin
        step_tbl = '{4'd15, 4'd15, 4'd15, 4'd14, 4'd14, 4'd14, 4'd14, 4'd13};
        rst4 = 1'b0;
        rst1 = 1'b0;
        edges(2);

        // Hold reset for 5 edges: both frozen at 15.
        rst4 = 1'b1;
        rst1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            edges(1);
            check_value("reset_hold4", out4, 4'hF);
            check_value("reset_hold1", out1, 4'hF);
        end

        // Release: step timing for DIV=4, consecutive steps for DIV=1.
        rst4 = 1'b0;
        rst1 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            edges(1);
            if (k <= 8) check_value("step_div4", out4, step_tbl[k-1]);
            check_value("step_div1", out1, 4'(15 - (k % 16)));
        end

        // Continue to E+64: value 0 held through E+63, wraps to 15 at E+64.
        edges(47);
        check_value("pre_wrap4", out4, 4'h0);
        edges(1);
        check_value("wrap4", out4, 4'hF);

        // Mid-count reset when Output=9 and prescaler at 2.
        rst4 = 1'b1;
        edges(1);
        rst4 = 1'b0;
        edges(26);
        check_value("midcnt_pre", out4, 4'd9);
        rst4 = 1'b1;
        edges(1);
        check_value("midcnt_rst", out4, 4'hF);
        rst4 = 1'b0;
        edges(3);
        check_value("midcnt_hold", out4, 4'hF);

        // Prescaler now at its terminal value: reset on the tick edge.
        rst4 = 1'b1;
        edges(1);
        check_value("rst_priority", out4, 4'hF);
        rst4 = 1'b0;
        edges(3);
        check_value("post_prio_hold", out4, 4'hF);
        edges(1);
        check_value("post_prio_step", out4, 4'd14);

        // Randomised reset pulses on both instances.
        for (int i = 0; i < 1500; i++) begin
            edges(1);
            rst4 = ($urandom_range(0, 79) == 0);
            rst1 = ($urandom_range(0, 39) == 0);
        end
        rst4 = 1'b0;
        rst1 = 1'b0;
        edges(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_block_counter4bit_down
`default_nettype wire
